repetition_stimulus: RTL
========================

# repetition_stimulus

Programmable stimulus generator for the repetition-operator examples. It is the driving side of the `a`/`b` checkers. On a `start` request it produces a run of consecutive `a` cycles, then an idle gap, then a series of single-cycle `b` pulses separated by idle gaps. The resulting traces satisfy the consecutive-repetition cover, the goto-repetition covers, and the `a |-> !b [*4]` and `b |=> !b` assumptions by construction. It sits beside the checker modules in the tutorial top level and feeds their `a`/`b` inputs.

## Interface
- `RUN_LEN`, default 5: number of consecutive cycles `a` is high; legal range ≥1.
- `B_COUNT`, default 2: number of `b` pulses per burst; legal range ≥1.
- `MIN_GAP`, default 4: base idle cycles between the last `a` and the first `b`; legal range ≥3.
- `B_GAP`, default 1: base idle cycles between consecutive `b` pulses; legal range ≥1.
- `clk`, input, 1: single clock; all logic on posedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: burst request; sampled only in IDLE.
- `abort`, input, 1: synchronous cancel of an in-flight burst.
- `extra_gap`, input, 4: extra idle cycles added to every gap; captured when `start` is accepted.
- `a`, output, 1: registered `a` stimulus.
- `b`, output, 1: registered `b` stimulus.
- `busy`, output, 1: high while a burst is in progress.
- `done`, output, 1: one-cycle pulse coincident with the final `b` pulse.

## Operation
- States and their outputs:
  - IDLE: all outputs 0.
  - RUN_A: `a`=1, `busy`=1.
  - GAP_A: `a`=0, `b`=0, `busy`=1.
  - PULSE_B: `b`=1, `busy`=1.
  - GAP_B: `a`=0, `b`=0, `busy`=1.
- Transitions:
  - IDLE → RUN_A when `start`=1. On that edge, latch `extra_gap` into `gap_x`.
  - RUN_A → GAP_A after `RUN_LEN` cycles.
  - GAP_A → PULSE_B after `MIN_GAP+gap_x` cycles.
  - PULSE_B → GAP_B if pulses emitted < `B_COUNT`; otherwise PULSE_B → IDLE.
  - GAP_B → PULSE_B after `B_GAP+gap_x` cycles.
- `done`=1 only in the PULSE_B cycle that emits pulse number `B_COUNT`.
- Counter widths:
  - Run counter is `$clog2(RUN_LEN+1)` bits.
  - Gap counter is wide enough for `max(MIN_GAP,B_GAP)+15` with no wrap.
  - Pulse counter is `$clog2(B_COUNT+1)` bits.
  - All counters clear on entry to each state.
- Guarantees by construction:
  - `a` and `b` are never high in the same cycle.
  - At least 3 zero cycles of `b` follow the last `a`.
  - `b` is never high on two consecutive cycles.
- `start` is ignored while `busy`=1, including the final PULSE_B cycle. No request queueing.
- `abort`=1 in any non-IDLE state: next state is IDLE, all outputs go to 0 on the next edge, `done` is not asserted. `abort` has priority over every other transition.
- `abort` in IDLE has no effect. `start` and `abort` high together in IDLE: `start` is accepted.
- `extra_gap` changes during a burst have no effect on that burst.

## Timing
- Reset (`rst_n`=0, asynchronous): state goes to IDLE; `a`, `b`, `busy`, `done` are 0; counters and `gap_x` are 0. Outputs go to 0 without waiting for a clock edge.
- Reset mid-burst aborts the burst with no `done`. The first `start` is accepted on the first posedge with `rst_n`=1.
- Burst timing, with `start` sampled at edge k and G = `MIN_GAP+gap_x`:
  - `a`=1 during cycles k+1 … k+RUN_LEN.
  - First `b` at cycle k+RUN_LEN+G+1.
  - Subsequent `b` pulses every `B_GAP+gap_x+1` cycles.
- Total `busy` length: RUN_LEN + G + B_COUNT + (B_COUNT−1)·(B_GAP+gap_x) cycles.
- `busy` is 0 in the cycle after `done`. Earliest next `start` is sampled in that cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use default parameters unless stated.

- **Basic burst.** Reset, then `start` sampled at edge 0 with `extra_gap`=0.
  - `a`=1 in cycles 1–5.
  - `b`=1 in cycles 10 and 12.
  - `done` in cycle 12.
  - `busy` in cycles 1–12; IDLE in cycle 13.
- **Extra gap.** `start` with `extra_gap`=3.
  - `a` in cycles 1–5.
  - `b` in cycles 13 and 18.
  - `done` in cycle 18.
- **Abort mid-burst.** `abort`=1 in cycle 7 (GAP_A).
  - Outputs 0 from cycle 8.
  - No `b` and no `done`.
  - New `start` in cycle 8 gives `a`=1 in cycles 9–13.
- **Start while busy.** `start` held high continuously from cycle 0.
  - First burst as in the basic case.
  - `start` pulses during `busy` are ignored.
  - Second burst: `start` sampled at edge 13, `a` in cycles 14–18.
- **Asynchronous reset.** `rst_n` dropped mid-clock during RUN_A.
  - `a` and `busy` fall immediately, before the next edge.
  - After release, IDLE and no `done`.
- **Parameter corner.** `RUN_LEN`=1, `B_COUNT`=1, `MIN_GAP`=3.
  - `a` in cycle 1.
  - `b` and `done` in cycle 5.
  - Bound checkers' covers hit and assumptions hold throughout.

Source files
------------

// File: rtl/repetition_stimulus_if.sv
// Handshake bundle between the stimulus generator and whoever drives it.
// The master side issues burst requests and observes the a/b trace;
// the slave side is the generator itself.
interface repetition_stimulus_if;
  logic       start;
  logic       abort;
  logic [3:0] extra_gap;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, extra_gap,
    input  a, b, busy, done
  );

  modport slave (
    input  start, abort, extra_gap,
    output a, b, busy, done
  );
endinterface

// File: rtl/repetition_stimulus.sv
// Stimulus generator for the repetition-operator checkers.
// A burst is: RUN_LEN cycles of a, an idle gap, then B_COUNT single-cycle
// b pulses separated by idle gaps. Every output comes straight from a flop
// loaded with the decode of the next state, so nothing is combinational
// from inputs to outputs and a/b line up with the state they belong to.
module repetition_stimulus #(
  parameter int RUN_LEN = 5,
  parameter int B_COUNT = 2,
  parameter int MIN_GAP = 4,
  parameter int B_GAP   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  repetition_stimulus_if.slave bus
);

  localparam int RW   = $clog2(RUN_LEN + 1);
  localparam int GMAX = ((MIN_GAP > B_GAP) ? MIN_GAP : B_GAP) + 15;
  localparam int GW   = $clog2(GMAX + 1);
  localparam int PW   = $clog2(B_COUNT + 1);

  localparam logic [RW-1:0] RUN_LAST   = RW'(RUN_LEN - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(B_COUNT - 1);
  localparam logic [GW-1:0] MIN_GAP_W  = GW'(MIN_GAP);
  localparam logic [GW-1:0] B_GAP_W    = GW'(B_GAP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_A   = 3'd1,
    GAP_A   = 3'd2,
    PULSE_B = 3'd3,
    GAP_B   = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [RW-1:0]   run_cnt, run_cnt_next;
  logic [GW-1:0]   gap_cnt, gap_cnt_next;
  logic [PW-1:0]   pulse_cnt, pulse_cnt_next;
  logic [3:0]      gap_x, gap_x_next;
  logic [GW-1:0]   gap_len;
  logic            a_reg, b_reg, busy_reg, done_reg;
  logic            a_next, b_next, busy_next, done_next;

  // Length of whichever gap we are currently in, widened so the +15 never wraps.
  always_comb begin
    gap_len = ((state == GAP_A) ? MIN_GAP_W : B_GAP_W) + GW'(gap_x);
  end

  // Next-state and counter logic; abort overrides every other transition.
  always_comb begin
    state_next     = state;
    run_cnt_next   = run_cnt;
    gap_cnt_next   = gap_cnt;
    pulse_cnt_next = pulse_cnt;
    gap_x_next     = gap_x;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next     = RUN_A;
          gap_x_next     = bus.extra_gap;
          run_cnt_next   = '0;
          gap_cnt_next   = '0;
          pulse_cnt_next = '0;
        end
      end
      RUN_A: begin
        if (run_cnt == RUN_LAST) begin
          state_next   = GAP_A;
          gap_cnt_next = '0;
        end else begin
          run_cnt_next = run_cnt + RW'(1);
        end
      end
      GAP_A, GAP_B: begin
        if (gap_cnt == gap_len - GW'(1)) begin
          state_next = PULSE_B;
        end else begin
          gap_cnt_next = gap_cnt + GW'(1);
        end
      end
      PULSE_B: begin
        // pulse_cnt holds the number of pulses already finished before this one.
        if (pulse_cnt == PULSE_LAST) begin
          state_next = IDLE;
        end else begin
          state_next     = GAP_B;
          gap_cnt_next   = '0;
          pulse_cnt_next = pulse_cnt + PW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.abort && (state != IDLE)) begin
      state_next     = IDLE;
      run_cnt_next   = '0;
      gap_cnt_next   = '0;
      pulse_cnt_next = '0;
    end
  end

  // Output decode of the upcoming state, loaded into the output flops below.
  always_comb begin
    a_next    = (state_next == RUN_A);
    b_next    = (state_next == PULSE_B);
    busy_next = (state_next != IDLE);
    done_next = (state_next == PULSE_B) && (pulse_cnt_next == PULSE_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_cnt   <= '0;
      gap_cnt   <= '0;
      pulse_cnt <= '0;
      gap_x     <= '0;
      a_reg     <= 1'b0;
      b_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_next;
      run_cnt   <= run_cnt_next;
      gap_cnt   <= gap_cnt_next;
      pulse_cnt <= pulse_cnt_next;
      gap_x     <= gap_x_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.a    = a_reg;
  assign bus.b    = b_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule
